// File: rtl/mux2_rr_stream_arbiter.sv
// Round-robin arbiter for two valid/ready packet streams feeding the Mux2 select path.
// Grant is held for a whole packet; winning beats land in a one-entry output register.
module mux2_rr_stream_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in0_valid,
  output logic             io_in0_ready,
  input  logic [WIDTH-1:0] io_in0_bits,
  input  logic             io_in0_last,
  input  logic             io_in1_valid,
  output logic             io_in1_ready,
  input  logic [WIDTH-1:0] io_in1_bits,
  input  logic             io_in1_last,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic             io_out_last,
  output logic             io_sel,
  output logic             io_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_r, state_next_s;
  logic             prio_r, prio_next_s;
  logic             load_s, act_s, gnt_s, xfer_s, beat_last_s;
  logic [WIDTH-1:0] beat_bits_s;
  logic             out_valid_r, out_last_r, sel_r, busy_r;
  logic [WIDTH-1:0] out_bits_r;

  assign load_s = !out_valid_r || io_out_ready;

  // Pick the candidate stream: locked source, else prio, else the other valid stream.
  always_comb begin
    act_s = 1'b0;
    gnt_s = prio_r;
    case (state_r)
      IDLE: begin
        if (prio_r ? io_in1_valid : io_in0_valid) begin
          act_s = 1'b1;
          gnt_s = prio_r;
        end else if (prio_r ? io_in0_valid : io_in1_valid) begin
          act_s = 1'b1;
          gnt_s = ~prio_r;
        end else begin
          act_s = 1'b0;
          gnt_s = prio_r;
        end
      end
      LOCK0: begin
        act_s = 1'b1;
        gnt_s = 1'b0;
      end
      LOCK1: begin
        act_s = 1'b1;
        gnt_s = 1'b1;
      end
      default: begin
        act_s = 1'b0;
        gnt_s = 1'b0;
      end
    endcase
  end

  // Ready goes only to the granted stream, and only when the output stage can load.
  always_comb begin
    io_in0_ready = 1'b0;
    io_in1_ready = 1'b0;
    if (!reset && act_s && load_s) begin
      io_in0_ready = !gnt_s;
      io_in1_ready = gnt_s;
    end else begin
      io_in0_ready = 1'b0;
      io_in1_ready = 1'b0;
    end
  end

  // Beat selected from the granted stream.
  always_comb begin
    xfer_s      = 1'b0;
    beat_bits_s = io_in0_bits;
    beat_last_s = io_in0_last;
    if (gnt_s) begin
      xfer_s      = io_in1_valid && io_in1_ready;
      beat_bits_s = io_in1_bits;
      beat_last_s = io_in1_last;
    end else begin
      xfer_s      = io_in0_valid && io_in0_ready;
      beat_bits_s = io_in0_bits;
      beat_last_s = io_in0_last;
    end
  end

  // Packet lock and priority rotation; prio moves only when a packet ends.
  always_comb begin
    state_next_s = state_r;
    prio_next_s  = prio_r;
    case (state_r)
      IDLE: begin
        if (xfer_s && beat_last_s) begin
          prio_next_s = ~gnt_s;
        end else if (xfer_s) begin
          state_next_s = gnt_s ? LOCK1 : LOCK0;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCK0, LOCK1: begin
        if (xfer_s && beat_last_s) begin
          state_next_s = IDLE;
          prio_next_s  = ~gnt_s;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        prio_next_s  = 1'b0;
      end
    endcase
  end

  // State, priority, busy flag and the single-entry output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      prio_r      <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_bits_r  <= {WIDTH{1'b0}};
      out_last_r  <= 1'b0;
      sel_r       <= 1'b0;
    end else begin
      state_r <= state_next_s;
      prio_r  <= prio_next_s;
      busy_r  <= (state_next_s != IDLE);
      if (xfer_s) begin
        out_valid_r <= 1'b1;
        out_bits_r  <= beat_bits_s;
        out_last_r  <= beat_last_s;
        sel_r       <= gnt_s;
      end else if (load_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign io_out_valid = out_valid_r;
  assign io_out_bits  = out_bits_r;
  assign io_out_last  = out_last_r;
  assign io_sel       = sel_r;
  assign io_busy      = busy_r;

endmodule
